// File: rtl/spi_line_receiver_pkg.sv
// Shared definitions for the SPI line receiver: command codes, line geometry
// defaults and the burst-decoder state encoding.
package spi_line_receiver_pkg;

    localparam logic [7:0] FRAME_START_CODE    = 8'h3F;
    localparam logic [7:0] LINE_CONT_CODE      = 8'h6B;
    localparam int         DEF_LINE_BYTES      = 480;
    localparam int         DEF_LINES_PER_FRAME = 240;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } state_e;

endpackage

// File: rtl/spi_line_receiver_input_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin with edge detection on
// the synchronized value. RST_VAL sets the level assumed while in reset, so a
// pin already at that level produces no edge once reset releases.
module spi_input_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain plus one extra flop to compare against for edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_line_receiver.sv
// SPI mode-0 slave front end: oversamples SCK/CS/MOSI, assembles bytes MSB
// first, decodes the burst command and streams payload bytes to the line FIFO
// with line/frame framing flags and length-error reporting.
module spi_line_receiver
    import spi_line_receiver_pkg::*;
#(
    parameter int         SYNC_STAGES     = 2,
    parameter int         LINE_BYTES      = DEF_LINE_BYTES,
    parameter int         LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter logic [7:0] CMD_FRAME_START = FRAME_START_CODE,
    parameter logic [7:0] CMD_LINE_CONT   = LINE_CONT_CODE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       spi_clock,
    input  logic       spi_cs,
    input  logic       spi_data,
    input  logic       fifo_full_i,
    output logic       write_to_fifo,
    output logic [7:0] fifo_data_o,
    output logic       frame_start_o,
    output logic       line_start_o,
    output logic       line_done_o,
    output logic       frame_done_o,
    output logic [7:0] line_index_o,
    output logic       short_line_o,
    output logic       long_line_o,
    output logic       overflow_o,
    output logic       bad_cmd_o
);

    localparam logic [9:0] LB        = 10'(LINE_BYTES);
    localparam logic [7:0] LAST_LINE = 8'(LINES_PER_FRAME - 1);

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic unused_sck;

    // CS resets to "asserted" so a burst interrupted by reset shows no
    // cs_fall and is ignored until the host starts a fresh one.
    spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clock(clock), .reset(reset), .async_i(spi_clock),
        .sync_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall));
    spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs (
        .clock(clock), .reset(reset), .async_i(spi_cs),
        .sync_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall));

    assign unused_sck = ^{sck_s, sck_fall};

    // MOSI needs no edge detect; same depth keeps it aligned with SCK.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) mosi_q <= '0;
        else       mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_data};
    end

    // A rise coinciding with cs_rise still belongs to the burst (CS was low
    // up to this cycle), so the last bit of a byte is never lost.
    logic       sample;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       byte_done_q;
    logic [1:0] cs_rise_q;
    logic       cs_end;

    assign sample = sck_rise & (~cs_s | cs_rise);
    assign cs_end = cs_rise_q[1];

    // Bit assembly; cs_rise discards a partial byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            if (sample) begin
                shift_q <= {shift_q[6:0], mosi_q[SYNC_STAGES-1]};
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_q   <= '0;
                    byte_done_q <= 1'b1;
                end else if (cs_rise) begin
                    bit_cnt_q <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
            end else if (cs_rise) begin
                bit_cnt_q <= '0;
            end
        end
    end

    // Delay the end of burst by two cycles so a byte completing on the last
    // SCK edge is fully accounted before the line is closed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cs_rise_q <= '0;
        else       cs_rise_q <= {cs_rise_q[0], cs_rise};
    end

    state_e     state_q, state_d;
    logic [7:0] line_index_q, line_index_d;
    logic       started_q, started_d;
    logic [9:0] byte_cnt_q, byte_cnt_d;
    logic       overflow_q, overflow_d;
    logic [7:0] data_q, data_d;
    logic       wr_q, wr_d, fs_q, fs_d, ls_q, ls_d, ld_q, ld_d;
    logic       fd_q, fd_d, sh_q, sh_d, lg_q, lg_d, bad_q, bad_d;

    // Burst decoder state and registered output strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            line_index_q <= '0;
            started_q    <= 1'b0;
            byte_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            data_q       <= '0;
            {wr_q, fs_q, ls_q, ld_q, fd_q, sh_q, lg_q, bad_q} <= '0;
        end else begin
            state_q      <= state_d;
            line_index_q <= line_index_d;
            started_q    <= started_d;
            byte_cnt_q   <= byte_cnt_d;
            overflow_q   <= overflow_d;
            data_q       <= data_d;
            {wr_q, fs_q, ls_q, ld_q, fd_q, sh_q, lg_q, bad_q} <=
                {wr_d, fs_d, ls_d, ld_d, fd_d, sh_d, lg_d, bad_d};
        end
    end

    // Command decode, payload routing and end-of-line classification.
    always_comb begin
        state_d      = state_q;
        line_index_d = line_index_q;
        started_d    = started_q;
        byte_cnt_d   = byte_cnt_q;
        overflow_d   = overflow_q;
        data_d       = data_q;
        {wr_d, fs_d, ls_d, ld_d, fd_d, sh_d, lg_d, bad_d} = '0;
        unique case (state_q)
            IDLE: if (cs_fall) state_d = CMD;
            CMD: begin
                if (byte_done_q) begin
                    byte_cnt_d = '0;
                    if (shift_q == CMD_FRAME_START) begin
                        fs_d         = 1'b1;
                        ls_d         = 1'b1;
                        line_index_d = '0;
                        started_d    = 1'b1;
                        overflow_d   = 1'b0;
                        state_d      = DATA;
                    end else if (shift_q == CMD_LINE_CONT) begin
                        ls_d      = 1'b1;
                        started_d = 1'b1;
                        if (!started_q)                line_index_d = '0;
                        else if (line_index_q != 8'hFF) line_index_d = line_index_q + 8'd1;
                        state_d = DATA;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = DROP;
                    end
                end else if (cs_end) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (byte_done_q) begin
                    if (fifo_full_i) begin
                        overflow_d = 1'b1;
                    end else if (byte_cnt_q < LB) begin
                        wr_d   = 1'b1;
                        data_d = shift_q;
                    end
                    if (byte_cnt_q != 10'h3FF) byte_cnt_d = byte_cnt_q + 10'd1;
                end else if (cs_end) begin
                    ld_d       = 1'b1;
                    sh_d       = (byte_cnt_q < LB);
                    lg_d       = (byte_cnt_q > LB);
                    fd_d       = (line_index_q == LAST_LINE);
                    byte_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            DROP: if (cs_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign write_to_fifo = wr_q;
    assign fifo_data_o   = data_q;
    assign frame_start_o = fs_q;
    assign line_start_o  = ls_q;
    assign line_done_o   = ld_q;
    assign frame_done_o  = fd_q;
    assign line_index_o  = line_index_q;
    assign short_line_o  = sh_q;
    assign long_line_o   = lg_q;
    assign overflow_o    = overflow_q;
    assign bad_cmd_o     = bad_q;

endmodule

// File: tb/tb_spi_line_receiver.sv
// Scoreboard bench for spi_line_receiver: bursts are driven bit by bit on the
// SPI pins, a line-level model pushes expected FIFO writes and line-end events,
// and a monitor pops and compares them as the DUT produces them.
module tb_spi_line_receiver;

    localparam int LB   = 480;
    localparam int LPF  = 240;
    localparam int HALF = 2;   // SCK half period in system clocks (4x ratio)

    logic       clock = 1'b0, reset = 1'b1;
    logic       spi_clock = 1'b0, spi_cs = 1'b1, spi_data = 1'b0, fifo_full_i = 1'b0;
    logic       write_to_fifo, frame_start_o, line_start_o, line_done_o, frame_done_o;
    logic       short_line_o, long_line_o, overflow_o, bad_cmd_o;
    logic [7:0] fifo_data_o, line_index_o;

    always #5 clock = ~clock;

    spi_line_receiver dut (
        .clock(clock), .reset(reset), .spi_clock(spi_clock), .spi_cs(spi_cs),
        .spi_data(spi_data), .fifo_full_i(fifo_full_i), .write_to_fifo(write_to_fifo),
        .fifo_data_o(fifo_data_o), .frame_start_o(frame_start_o), .line_start_o(line_start_o),
        .line_done_o(line_done_o), .frame_done_o(frame_done_o), .line_index_o(line_index_o),
        .short_line_o(short_line_o), .long_line_o(long_line_o), .overflow_o(overflow_o),
        .bad_cmd_o(bad_cmd_o));

    typedef struct {
        bit sh;
        bit lg;
        bit fd;
        int idx;
    } ev_t;

    logic [7:0] exp_wr[$];
    ev_t        exp_ev[$];
    logic [7:0] payload[$];
    bit         fullm[$];

    int checks = 0, passed = 0;
    int n_fs = 0, n_ls = 0, n_bad = 0, e_fs = 0, e_ls = 0, e_bad = 0;
    int m_idx = 0;
    bit m_started = 0, m_ovf = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: pops expectations whenever the DUT emits a write or line end.
    logic [7:0] mon_e;
    ev_t        mon_ev;
    always @(negedge clock) begin
        if (!reset) begin
            if (frame_start_o) n_fs++;
            if (line_start_o)  n_ls++;
            if (bad_cmd_o)     n_bad++;
            if (write_to_fifo) begin
                chk("write_expected", int'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    mon_e = exp_wr.pop_front();
                    chk("fifo_data", fifo_data_o, mon_e);
                end
            end
            if (line_done_o) begin
                chk("line_done_expected", int'(exp_ev.size() != 0), 1);
                if (exp_ev.size() != 0) begin
                    mon_ev = exp_ev.pop_front();
                    chk("short_line", short_line_o, mon_ev.sh);
                    chk("long_line",  long_line_o,  mon_ev.lg);
                    chk("frame_done", frame_done_o, mon_ev.fd);
                    chk("line_index_at_done", line_index_o, mon_ev.idx);
                end
            end else if (short_line_o | long_line_o | frame_done_o) begin
                chk("flags_without_line_done", int'({short_line_o, long_line_o, frame_done_o}), 0);
            end
        end
    end

    // Line-level reference: what a burst with this command and these
    // complete payload bytes must produce.
    task automatic model_burst(input logic [7:0] cmd, input bit closes);
        bit valid = 0;
        int cnt = payload.size();
        if (cmd == 8'h3F) begin
            m_idx = 0; m_started = 1; m_ovf = 0; e_fs++; e_ls++; valid = 1;
        end else if (cmd == 8'h6B) begin
            m_idx = !m_started ? 0 : (m_idx == 255 ? 255 : m_idx + 1);
            m_started = 1; e_ls++; valid = 1;
        end else begin
            e_bad++;
        end
        if (valid) begin
            foreach (payload[j]) begin
                if (fullm[j])    m_ovf = 1;
                else if (j < LB) exp_wr.push_back(payload[j]);
            end
            if (closes) exp_ev.push_back('{sh: cnt < LB, lg: cnt > LB, fd: m_idx == LPF - 1, idx: m_idx});
        end
    endtask

    task automatic send_bit(input bit b);
        spi_data  = b;
        spi_clock = 1'b0;
        repeat (HALF) @(negedge clock);
        spi_clock = 1'b1;
        repeat (HALF) @(negedge clock);
    endtask

    // fifo_full is applied mid-byte so it is stable when that byte completes.
    task automatic send_byte(input logic [7:0] b, input bit full);
        for (int i = 7; i >= 0; i--) begin
            if (i == 3) fifo_full_i = full;
            send_bit(b[i]);
        end
    endtask

    task automatic end_burst();
        spi_clock = 1'b0;
        repeat (4) @(negedge clock);
        spi_cs = 1'b1;
        repeat (14) @(negedge clock);
        fifo_full_i = 1'b0;
    endtask

    task automatic burst(input logic [7:0] cmd, input int cut);
        model_burst(cmd, 1'b1);
        spi_cs = 1'b0;
        repeat (4) @(negedge clock);
        send_byte(cmd, 1'b0);
        foreach (payload[j]) send_byte(payload[j], fullm[j]);
        for (int i = 0; i < cut; i++) send_bit(1'($urandom));
        end_burst();
    endtask

    task automatic fill(input int n);
        payload.delete();
        fullm.delete();
        for (int i = 0; i < n; i++) begin
            payload.push_back(8'($urandom));
            fullm.push_back(1'b0);
        end
    endtask

    task automatic checkpoint(input string tag);
        chk({tag, "_writes_drained"}, exp_wr.size(), 0);
        chk({tag, "_lines_drained"},  exp_ev.size(), 0);
        chk({tag, "_frame_starts"},   n_fs, e_fs);
        chk({tag, "_line_starts"},    n_ls, e_ls);
        chk({tag, "_bad_cmds"},       n_bad, e_bad);
        chk({tag, "_overflow"},       overflow_o, m_ovf);
        chk({tag, "_line_index"},     line_index_o, m_idx);
    endtask

    initial begin
        repeat (4) @(negedge clock);
        chk("rst_write",      write_to_fifo, 0);
        chk("rst_line_index", line_index_o, 0);
        chk("rst_overflow",   overflow_o, 0);
        chk("rst_flags", int'({frame_start_o, line_start_o, line_done_o, frame_done_o,
                               short_line_o, long_line_o, bad_cmd_o}), 0);
        reset = 1'b0;
        repeat (6) @(negedge clock);

        // Exact-length frame-start line, data 0x00..0xDF wrapping.
        fill(LB);
        foreach (payload[j]) payload[j] = 8'(j % 224);
        burst(8'h3F, 0);
        checkpoint("full_line");

        fill(30);
        burst(8'h6B, 0);
        checkpoint("short_line");

        // Complete frame; frame_done on the 240th line.
        for (int l = 0; l < LPF; l++) begin
            fill($urandom_range(0, 1));
            burst(l == 0 ? 8'h3F : 8'h6B, 0);
        end
        checkpoint("frame");

        // Line index saturates rather than wrapping.
        for (int l = 0; l < 18; l++) begin
            fill(0);
            burst(8'h6B, 0);
        end
        checkpoint("index_sat");

        fill(10);
        burst(8'h55, 0);
        checkpoint("bad_cmd");

        fill(12);
        for (int j = 5; j <= 9; j++) fullm[j] = 1'b1;
        burst(8'h3F, 0);
        checkpoint("overflow_set");
        fill(3);
        burst(8'h6B, 0);
        checkpoint("overflow_sticky");
        fill(2);
        burst(8'h3F, 0);
        checkpoint("overflow_cleared");

        // CS raised three bits into a byte: partial byte dropped.
        fill(2);
        burst(8'h6B, 3);
        checkpoint("cs_cut");
        fill(4);
        burst(8'h6B, 0);
        checkpoint("after_cut");

        // Reset three bits into a byte, CS held low through and after reset.
        fill(2);
        fullm[1] = 1'b1;
        model_burst(8'h6B, 1'b0);
        spi_cs = 1'b0;
        repeat (4) @(negedge clock);
        send_byte(8'h6B, 1'b0);
        foreach (payload[j]) send_byte(payload[j], fullm[j]);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        chk("pre_reset_overflow", overflow_o, 1);
        reset = 1'b1;
        m_idx = 0; m_started = 0; m_ovf = 0;
        repeat (3) @(negedge clock);
        chk("in_reset_line_index", line_index_o, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        for (int i = 0; i < 3; i++) send_byte(8'h3F, 1'b0);
        end_burst();
        checkpoint("after_reset");
        fill(3);
        burst(8'h6B, 0);
        checkpoint("first_after_reset");

        // Randomized bursts.
        for (int k = 0; k < 20; k++) begin
            logic [7:0] cmd;
            int sel = $urandom_range(0, 9);
            cmd = sel < 3 ? 8'h3F : (sel < 8 ? 8'h6B : 8'($urandom));
            fill($urandom_range(0, 16));
            foreach (fullm[j]) fullm[j] = ($urandom_range(0, 9) == 0);
            burst(cmd, $urandom_range(0, 7));
            checkpoint("random");
        end

        // Over-length line: the 481st byte is counted but not written.
        fill(LB + 1);
        burst(8'h6B, 0);
        checkpoint("long_line");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
